// File: rtl/lane_unpacker.sv
// Replays the lanes of one parity-protected packed word, one lane per cycle, on a valid/ready stream.
// Define LANE_UNPACKER_PARITY_EN to enable the parity check, out_perr and err_count.
module lane_unpacker #(
  parameter int LANES = 10,
  parameter int W     = 4,
  parameter int IDXW  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_data,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic                 out_perr,
  output logic [7:0]           err_count
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [LANES*W-1:0]   word_q;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 last;
  logic                 accept;
  logic [W-1:0]         lanes [LANES];

  assign last     = (idx_q == IDXW'(LANES - 1));
  assign in_ready = (state_q == IDLE) | ((state_q == DRAIN) & last & out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (!last) begin
            idx_d = idx_q + IDXW'(1);
          end else if (in_valid) begin
            idx_d = '0;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) word_q <= in_data;
    end
  end

  // Lane 0 lives in the MSBs of the held word.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lanes[i] = word_q[(LANES-i)*W-1 -: W];
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign out_data  = lanes[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = last;

`ifdef LANE_UNPACKER_PARITY_EN
  logic       perr_in;
  logic       perr_q;
  logic [7:0] err_q;

  assign perr_in = (^in_data) != in_parity;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
      err_q  <= '0;
    end else if (accept) begin
      perr_q <= perr_in;
      if (perr_in && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign out_perr  = perr_q;
  assign err_count = err_q;
`else
  logic unused_parity;
  assign unused_parity = in_parity;
  assign out_perr      = 1'b0;
  assign err_count     = 8'h00;
`endif

endmodule

// File: tb/tb_lane_unpacker.sv
// Randomised and directed stimulus for lane_unpacker, checked against a lane-queue reference model.
module tb_lane_unpacker;

  localparam int LANES = 10;
  localparam int W     = 4;
  localparam int IDXW  = 4;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [LANES*W-1:0] in_data;
  logic               in_parity;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic [IDXW-1:0]    out_idx;
  logic               out_last;
  logic               out_perr;
  logic [7:0]         err_count;

  lane_unpacker #(.LANES(LANES), .W(W), .IDXW(IDXW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_parity (in_parity),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_perr  (out_perr),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned data;
    int unsigned idx;
    bit          perr;
  } lane_t;

  lane_t lane_q[$];
  int    err_exp  = 0;
  bit    last_acc = 1'b0;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit exp_in_ready();
    return (lane_q.size() == 0) || (lane_q.size() == 1 && out_ready);
  endfunction

  // One cycle: compare outputs against the model, then advance the model across the rising edge.
  task automatic step();
    bit acc;
    bit perr;
    #1;
    if (reset_n) begin
      check("out_valid", out_valid, lane_q.size() > 0);
      check("in_ready", in_ready, exp_in_ready());
      check("err_count", err_count, err_exp);
      if (lane_q.size() > 0) begin
        check("out_data", out_data, lane_q[0].data);
        check("out_idx", out_idx, lane_q[0].idx);
        check("out_last", out_last, lane_q[0].idx == LANES - 1);
        check("out_perr", out_perr, lane_q[0].perr);
      end
    end
    acc = reset_n && in_valid && exp_in_ready();
    @(posedge clock);
    last_acc = acc;
    if (!reset_n) begin
      lane_q.delete();
      err_exp = 0;
    end else begin
      if (lane_q.size() > 0 && out_ready) void'(lane_q.pop_front());
      if (acc) begin
`ifdef LANE_UNPACKER_PARITY_EN
        perr = (^in_data) != in_parity;
`else
        perr = 1'b0;
`endif
        for (int i = 0; i < LANES; i++)
          lane_q.push_back('{data: in_data[(LANES-i)*W-1 -: W], idx: i, perr: perr});
        if (perr && err_exp < 255) err_exp++;
      end
    end
    @(negedge clock);
  endtask

  task automatic send_word(input logic [LANES*W-1:0] d, input logic p);
    int budget;
    in_valid  = 1'b1;
    in_data   = d;
    in_parity = p;
    budget    = 0;
    do begin
      step();
      budget++;
    end while (!last_acc && budget < 40);
    if (!last_acc) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle_steps(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idx(input int idx);
    int budget = 0;
    while ((lane_q.size() == 0 || lane_q[0].idx != idx) && budget < 40) begin
      step();
      budget++;
    end
    check("reach_idx", lane_q.size() > 0 && lane_q[0].idx == idx, 1'b1);
  endtask

  initial begin
    logic [LANES*W-1:0] w;
    int sent;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_parity = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_perr", out_perr, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;

    // Good parity, then bad parity on the same word.
    out_ready = 1'b1;
    send_word(40'h0123456789, 1'b1);
    idle_steps(12);
    send_word(40'h0123456789, 1'b0);
    idle_steps(12);
`ifdef LANE_UNPACKER_PARITY_EN
    check("err_after_bad", err_count, 1);
`endif

    // Two words back to back.
    send_word(40'hFEDCBA9876, 1'b0);
    send_word(40'h13579BDF02, 1'b1);
    idle_steps(12);

    // Downstream stall at lane 3.
    in_valid  = 1'b1;
    in_data   = 40'h0123456789;
    in_parity = 1'b1;
    step();
    in_valid = 1'b0;
    run_until_idx(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b1;
    idle_steps(10);

    // Reset in the middle of a word.
    send_word(40'hA5A5A5A5A5, 1'b1);
    in_valid = 1'b0;
    run_until_idx(6);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_idx", out_idx, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clock);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 40'({$urandom(), $urandom()});
      in_parity = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle_steps(12);

    // Saturation of the error counter.
    sent = 0;
    while (sent < 300) begin
      w = 40'({$urandom(), $urandom()});
      send_word(w, ~(^w));
      sent++;
    end
    idle_steps(12);
`ifdef LANE_UNPACKER_PARITY_EN
    check("err_saturated", err_count, 8'hFF);
`else
    check("err_tied_zero", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
